// File: rtl/fifo_sync_flags_pkg.sv
// Shared types and helpers for the fifo_sync_flags block.
// Pointer/level width helpers and the wrap-around pointer increment.
// Holds no logic of its own; it is imported by the interface, the top and the bench.
package fifo_sync_flags_pkg;

    // Default geometry, used as the interface and top parameter defaults
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AF_LEVEL   = 12;
    localparam int DEF_AE_LEVEL   = 4;

    // Accepted operation for one cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Pointer width. A depth of 1 still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Level width. The level must be able to hold DEPTH itself.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Increments a pointer with an explicit DEPTH-1 -> 0 wrap, so that
    // non-power-of-two depths never address a slot that does not exist.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Handshake and status bundle between a byte producer/consumer and fifo_sync_flags.
// master: the client that drives the requests. slave: the FIFO itself.
// The parameters must match those of the fifo_sync_flags instance it connects to.
interface fifo_sync_flags_if
    import fifo_sync_flags_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int LVL_W = lvl_w(DEPTH);

    // Control from the client
    logic                  flush;
    logic                  clear_err;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;

    // Data and status from the FIFO
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, clear_err, write_en, data_in, read_en,
        input  data_out, full, empty, almost_full, almost_empty, level,
               overflow, underflow
    );

    modport slave (
        input  flush, clear_err, write_en, data_in, read_en,
        output data_out, full, empty, almost_full, almost_empty, level,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_flags_strobe_qual.sv
// Rising-edge qualifier: o_strobe is high for one cycle per low->high change of i_level.
// Latency: combinational against a one-cycle history register.
// Backpressure: none; a level held high yields one strobe. History resets to 1, so a level high through reset is ignored.
module fifo_sync_flags_strobe_qual (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_strobe
);

    logic r_prev;

    // Previous sample of the level; reset to 1 so no edge is seen coming out of reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_strobe = i_level & ~r_prev;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock show-ahead FIFO with level, almost flags, flush and sticky overflow/underflow.
// Latency: head visible with 0 latency, a write is readable 1 cycle later, flags follow the registered level.
// Backpressure: writes when full / reads when empty are dropped and raise a sticky error. Define FIFO_STROBE_EDGE_EN to use edge strobes.
module fifo_sync_flags
    import fifo_sync_flags_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic              i_clock,
    input  logic              i_reset,
    fifo_sync_flags_if.slave  io_fifo
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_LEVEL);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    // Storage: plain array with asynchronous read so it maps to distributed RAM
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic w_wr_req;
    logic w_rd_req;
    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_ovf_evt;
    logic w_unf_evt;
    op_e  w_op;

    // Pointer increment with explicit wrap at DEPTH-1
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return PTR_W'(ptr_next(32'(p), DEPTH));
    endfunction

`ifdef FIFO_STROBE_EDGE_EN
    // Edge mode: each enable must go low and high again to request another operation
    fifo_sync_flags_strobe_qual u_wr_qual (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_level  (io_fifo.write_en),
        .o_strobe (w_wr_req)
    );

    fifo_sync_flags_strobe_qual u_rd_qual (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_level  (io_fifo.read_en),
        .o_strobe (w_rd_req)
    );
`else
    // Level mode: one operation per clock while the enable is high
    assign w_wr_req = io_fifo.write_en;
    assign w_rd_req = io_fifo.read_en;
`endif

    // Acceptance is decided on this cycle's registered level only, so a full
    // FIFO rejects a write even when a read frees a slot in the same cycle,
    // and an empty FIFO rejects a read even when a write arrives alongside it.
    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_wr_ok   = w_wr_req & ~w_full;
    assign w_rd_ok   = w_rd_req & ~w_empty;
    assign w_op      = op_e'({w_wr_ok, w_rd_ok});

    // A flush swallows that cycle's requests, including their error events
    assign w_ovf_evt = w_wr_req & w_full  & ~io_fifo.flush;
    assign w_unf_evt = w_rd_req & w_empty & ~io_fifo.flush;

    // Storage write: contents are deliberately left alone by reset and flush
    always_ff @(posedge i_clock) begin
        if (!i_reset && !io_fifo.flush && w_wr_ok) begin
            r_mem[r_wr_ptr] <= io_fifo.data_in;
        end
    end

    // Pointers and level: reset, then flush, then the accepted operation
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (io_fifo.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    r_wr_ptr <= inc_ptr(r_wr_ptr);
                    r_level  <= r_level + LVL_ONE;
                end
                OP_POP: begin
                    r_rd_ptr <= inc_ptr(r_rd_ptr);
                    r_level  <= r_level - LVL_ONE;
                end
                OP_BOTH: begin
                    r_wr_ptr <= inc_ptr(r_wr_ptr);
                    r_rd_ptr <= inc_ptr(r_rd_ptr);
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky errors: clear_err drops them, but a new event in the same cycle keeps the flag set
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~io_fifo.clear_err) | w_ovf_evt;
            r_underflow <= (r_underflow & ~io_fifo.clear_err) | w_unf_evt;
        end
    end

    // Show-ahead head entry and level-derived status
    assign io_fifo.data_out     = r_mem[r_rd_ptr];
    assign io_fifo.full         = w_full;
    assign io_fifo.empty        = w_empty;
    assign io_fifo.almost_full  = (r_level >= LVL_AF);
    assign io_fifo.almost_empty = (r_level <= LVL_AE);
    assign io_fifo.level        = r_level;
    assign io_fifo.overflow     = r_overflow;
    assign io_fifo.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags (DEPTH=16, DATA_WIDTH=8, AF=12, AE=4).
// A queue holds the entries the bench expects the FIFO to contain; pops are compared against data_out.
// With FIFO_STROBE_EDGE_EN defined only the reset and edge-strobe scenarios run.
module tb_fifo_sync_flags;
    import fifo_sync_flags_pkg::*;

    localparam int DW = 8;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_sync_flags_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    fifo_sync_flags #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .AF_LEVEL   (12),
        .AE_LEVEL   (4)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_fifo (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [DW-1:0] sb[$];
    int            m_level;
    bit            m_ovf;
    bit            m_unf;

    // Per-cycle observations
    logic [DW-1:0] head_before;
    logic [DW-1:0] popped;
    bit            popped_vld;

    // Drives one clock of requests, updates the reference, samples #1 after the edge
    task automatic cyc(input bit we, input logic [DW-1:0] din, input bit re,
                       input bit fl, input bit ce);
        bit full_now, empty_now, ev_o, ev_u;
        bus.write_en  = we;
        bus.data_in   = din;
        bus.read_en   = re;
        bus.flush     = fl;
        bus.clear_err = ce;
        head_before   = bus.data_out;
        popped_vld    = 1'b0;
        if (fl) begin
            sb.delete();
            m_ovf = m_ovf && !ce;
            m_unf = m_unf && !ce;
        end else begin
            full_now  = (sb.size() == DP);
            empty_now = (sb.size() == 0);
            ev_o      = we && full_now;
            ev_u      = re && empty_now;
            if (re && !empty_now) begin
                popped     = sb.pop_front();
                popped_vld = 1'b1;
            end
            if (we && !full_now) sb.push_back(din);
            m_ovf = (m_ovf && !ce) || ev_o;
            m_unf = (m_unf && !ce) || ev_u;
        end
        m_level = sb.size();
        @(posedge clk);
        #1;
        bus.write_en  = 1'b0;
        bus.read_en   = 1'b0;
        bus.flush     = 1'b0;
        bus.clear_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.write_en  = 1'b1;
        bus.read_en   = 1'b1;
        bus.data_in   = 8'hC3;
        bus.flush     = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        rst = 1'b0;
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b want 1", bus.almost_empty); end
        total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", bus.almost_full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_unf: got %b want 0", bus.underflow); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DP; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            total++; if (bus.level !== 5'(i + 1)) begin bad++; $display("FAIL fill_level: got %0d want %0d", bus.level, i + 1); end
            total++; if (bus.almost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_af: got %b at level %0d", bus.almost_full, i + 1); end
            total++; if (bus.almost_empty !== (i + 1 <= 4)) begin bad++; $display("FAIL fill_ae: got %b at level %0d", bus.almost_empty, i + 1); end
            total++; if (bus.full !== (i + 1 == DP)) begin bad++; $display("FAIL fill_full: got %b at level %0d", bus.full, i + 1); end
        end
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", bus.level); end
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL ovf_unf: got %b want 0", bus.underflow); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < DP; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++; if (!popped_vld || head_before !== popped) begin bad++; $display("FAIL drain_data: got %h want %h", head_before, popped); end
            total++; if (bus.empty !== (m_level == 0)) begin bad++; $display("FAIL drain_empty: got %b at level %0d", bus.empty, m_level); end
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_set: got %b want 1", bus.underflow); end
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL unf_level: got %0d want 0", bus.level); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
    endtask

    task automatic test_wrap();
        bit we, re;
        for (int i = 0; i < 90; i++) begin
            we = ($urandom_range(0, 99) < 60);
            re = ($urandom_range(0, 99) < 45);
            cyc(we, DW'($urandom), re, 1'b0, 1'b0);
            if (popped_vld) begin
                total++; if (head_before !== popped) begin bad++; $display("FAIL wrap_data: got %h want %h", head_before, popped); end
            end
            total++; if (bus.level !== 5'(m_level)) begin bad++; $display("FAIL wrap_level: got %0d want %0d", bus.level, m_level); end
        end
        for (int i = 0; i < 2 * DP && m_level > 0; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++; if (head_before !== popped) begin bad++; $display("FAIL wrap_drain: got %h want %h", head_before, popped); end
        end
        total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_end: got level %0d empty %b want 0 1", bus.level, bus.empty); end
        total++; if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin bad++; $display("FAIL wrap_err: got %b%b want %b%b", bus.overflow, bus.underflow, m_ovf, m_unf); end
    endtask

    task automatic test_simultaneous();
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < DP; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        total++; if (head_before !== 8'h80) begin bad++; $display("FAIL full_both_data: got %h want 80", head_before); end
        total++; if (bus.level !== 5'd15) begin bad++; $display("FAIL full_both_level: got %0d want 15", bus.level); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL full_both_ovf: got %b want 1", bus.overflow); end
        for (int i = 0; i < DP && m_level > 0; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++; if (head_before !== popped) begin bad++; $display("FAIL full_both_drain: got %h want %h", head_before, popped); end
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL empty_both_level: got %0d want 1", bus.level); end
        total++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL empty_both_err: got ovf=%b unf=%b want 0 1", bus.overflow, bus.underflow); end
        total++; if (bus.data_out !== 8'h5A) begin bad++; $display("FAIL empty_both_data: got %h want 5a", bus.data_out); end
    endtask

    task automatic test_flush();
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        total++; if (bus.level !== 5'd9) begin bad++; $display("FAIL flush_pre_level: got %0d want 9", bus.level); end
        cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL flush_level: got %0d empty %b want 0 1", bus.level, bus.empty); end
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL flush_err: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        total++; if (bus.data_out !== 8'h11 || bus.level !== 5'd1) begin bad++; $display("FAIL flush_after: got %h lvl %0d want 11 1", bus.data_out, bus.level); end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL flush_unf: got %b want 1", bus.underflow); end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL clr_vs_event: got %b want 1", bus.underflow); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL clr_only: got %b want 0", bus.underflow); end
    endtask

    task automatic test_strobe();
        rst = 1'b1;
        bus.write_en = 1'b1;
        bus.data_in  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL strobe_thru_reset: got %0d want 0", bus.level); end
        bus.write_en = 1'b0;
        @(posedge clk);
        #1;
        bus.write_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL strobe_held: got %0d want 1", bus.level); end
        total++; if (bus.data_out !== 8'h77) begin bad++; $display("FAIL strobe_data: got %h want 77", bus.data_out); end
        bus.read_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.read_en = 1'b0;
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL strobe_read: got %0d want 0", bus.level); end
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL strobe_unf: got %b want 0", bus.underflow); end
    endtask

    initial begin
        bus.write_en  = 1'b0;
        bus.read_en   = 1'b0;
        bus.data_in   = '0;
        bus.flush     = 1'b0;
        bus.clear_err = 1'b0;
        rst           = 1'b1;
        test_reset();
`ifdef FIFO_STROBE_EDGE_EN
        test_strobe();
`else
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
